// File: rtl/wb_regfile_pkg.sv
// -----------------------------------------------------------------------------
// cpu_defs: shared pipeline definitions used by the write-back stage, MEM/WB,
// the forwarding unit and the hazard unit.
//   DATA_W      register / datapath width
//   REG_ADDR_W  width of a register index
//   NREGS       number of architectural registers (r0 hardwired to zero)
//   CNT_W       default width of the committed-write counter
//   ZERO_REG    index of the hardwired zero register
//   wb_src_e    write-back source select encoding (matches MemtoReg)
// -----------------------------------------------------------------------------
package cpu_defs;

  localparam int DATA_W     = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NREGS      = 32;
  localparam int CNT_W      = 32;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  localparam reg_addr_t ZERO_REG = 5'd0;

  // MemtoReg = 1 selects load data, 0 selects the ALU result.
  typedef enum logic {
    WB_SRC_ALU = 1'b0,
    WB_SRC_MEM = 1'b1
  } wb_src_e;

endpackage : cpu_defs

// File: rtl/wb_regfile_wb_mux.sv
// -----------------------------------------------------------------------------
// wb_mux: 2:1 write-back value select. Purely combinational; also instantiated
// by the forwarding unit so both see the identical selected value.
// Ports:
//   sel_i       write-back source (WB_SRC_MEM = load data, WB_SRC_ALU = ALU)
//   mem_data_i  load data from MEM/WB
//   alu_data_i  ALU result from MEM/WB
//   wb_data_o   selected write-back value
// -----------------------------------------------------------------------------
module wb_mux
  import cpu_defs::*;
#(
  parameter int W = DATA_W
) (
  input  wb_src_e      sel_i,
  input  logic [W-1:0] mem_data_i,
  input  logic [W-1:0] alu_data_i,
  output logic [W-1:0] wb_data_o
);

  assign wb_data_o = (sel_i == WB_SRC_MEM) ? mem_data_i : alu_data_i;

endmodule : wb_mux

// File: rtl/wb_regfile.sv
// -----------------------------------------------------------------------------
// wb_regfile: write-back end of the MEM/WB pipeline register. Selects the
// write-back value, commits it to the 32x32 GPR file, serves two combinational
// read ports to ID with write-through bypass, and counts committed writes.
// Ports:
//   clk                   system clock, all state on the rising edge
//   rst                   synchronous active-high reset (regs and counter -> 0)
//   RegWrite_in           commit enable from MEM/WB
//   MemtoReg_in           1 = load data, 0 = ALU result
//   D_MEM_read_data_in    load data from MEM/WB
//   D_MEM_read_addr_in    ALU result from MEM/WB
//   MEM_WB_RegisterRd_in  destination register index
//   rs_addr / rt_addr     ID read port indices
//   rs_data / rt_data     ID read port data (0 while rst is high)
//   wb_data               selected write-back value, for the forwarding unit
//   wb_count              committed writes since reset, wraps modulo 2^CNT_W
// -----------------------------------------------------------------------------
module wb_regfile #(
  parameter int DATA_W = cpu_defs::DATA_W,
  parameter int NREGS  = cpu_defs::NREGS,
  parameter int CNT_W  = cpu_defs::CNT_W
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           RegWrite_in,
  input  logic                           MemtoReg_in,
  input  logic [DATA_W-1:0]              D_MEM_read_data_in,
  input  logic [DATA_W-1:0]              D_MEM_read_addr_in,
  input  logic [cpu_defs::REG_ADDR_W-1:0] MEM_WB_RegisterRd_in,
  input  logic [cpu_defs::REG_ADDR_W-1:0] rs_addr,
  input  logic [cpu_defs::REG_ADDR_W-1:0] rt_addr,
  output logic [DATA_W-1:0]              rs_data,
  output logic [DATA_W-1:0]              rt_data,
  output logic [DATA_W-1:0]              wb_data,
  output logic [CNT_W-1:0]               wb_count
);

  import cpu_defs::*;

  logic [DATA_W-1:0] regs_q [NREGS];
  logic [CNT_W-1:0]  wb_count_q;
  logic [CNT_W-1:0]  wb_count_d;
  logic              commit_req;

  // Write-back value select, shared implementation with the forwarding unit.
  wb_mux #(
    .W (DATA_W)
  ) u_wb_mux (
    .sel_i      (wb_src_e'(MemtoReg_in)),
    .mem_data_i (D_MEM_read_data_in),
    .alu_data_i (D_MEM_read_addr_in),
    .wb_data_o  (wb_data)
  );

  // A write to r0 is not a commit: no state change and no count.
  assign commit_req = RegWrite_in && (MEM_WB_RegisterRd_in != ZERO_REG);
  assign wb_count_d = commit_req ? wb_count_q + CNT_W'(1) : wb_count_q;

  // Reset has priority, so a write pending on a reset edge is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the array is reset explicitly because software-visible registers
      // must read 0 after reset; this keeps it in flops rather than a RAM macro.
      for (int i = 0; i < NREGS; i++) begin
        // NOTE: state uses <= so every flop samples pre-edge values and the
        // result does not depend on block ordering.
        regs_q[i] <= '0;
      end
      wb_count_q <= '0;
    end else begin
      if (commit_req) begin
        regs_q[MEM_WB_RegisterRd_in] <= wb_data;
      end
      wb_count_q <= wb_count_d;
    end
  end

  // Read ports: r0 and reset force zero; a matching commit in flight is
  // bypassed so ID sees the value WB writes on this same edge.
  always_comb begin
    // NOTE: default first so every path assigns the output and no latch forms.
    rs_data = '0;
    if (!rst && (rs_addr != ZERO_REG)) begin
      if (commit_req && (MEM_WB_RegisterRd_in == rs_addr)) begin
        rs_data = wb_data;
      end else begin
        rs_data = regs_q[rs_addr];
      end
    end
  end

  always_comb begin
    rt_data = '0;
    if (!rst && (rt_addr != ZERO_REG)) begin
      if (commit_req && (MEM_WB_RegisterRd_in == rt_addr)) begin
        rt_data = wb_data;
      end else begin
        rt_data = regs_q[rt_addr];
      end
    end
  end

  assign wb_count = wb_count_q;

endmodule : wb_regfile

// File: tb/tb_wb_regfile.sv
// -----------------------------------------------------------------------------
// tb_wb_regfile: scoreboard bench for wb_regfile. The stimulus process drives
// inputs just after each rising edge and queues the values the outputs must
// show in that cycle; the monitor pops and compares on the falling edge.
// A second instance with a 4-bit counter exercises counter wrap-around.
// -----------------------------------------------------------------------------
module tb_wb_regfile;

  typedef enum logic [2:0] {
    S_RS, S_RT, S_WB, S_CNT, S_CNT4, S_RS4, S_RT4, S_WB4
  } sig_e;

  typedef struct {
    sig_e        sig;
    logic [31:0] exp;
    string       name;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        reg_write;
  logic        mem_to_reg;
  logic [31:0] mem_data;
  logic [31:0] alu_data;
  logic [4:0]  rd;
  logic [4:0]  rs_a;
  logic [4:0]  rt_a;

  logic [31:0] rs_data, rt_data, wb_data, wb_count;
  logic [31:0] rs_data4, rt_data4, wb_data4;
  logic [3:0]  wb_count4;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic        stim_done = 1'b0;
  logic [31:0] mregs [32];
  int          mcnt;

  always #5 clk = ~clk;

  wb_regfile u_dut (
    .clk                  (clk),
    .rst                  (rst),
    .RegWrite_in          (reg_write),
    .MemtoReg_in          (mem_to_reg),
    .D_MEM_read_data_in   (mem_data),
    .D_MEM_read_addr_in   (alu_data),
    .MEM_WB_RegisterRd_in (rd),
    .rs_addr              (rs_a),
    .rt_addr              (rt_a),
    .rs_data              (rs_data),
    .rt_data              (rt_data),
    .wb_data              (wb_data),
    .wb_count             (wb_count)
  );

  wb_regfile #(
    .CNT_W (4)
  ) u_dut_w4 (
    .clk                  (clk),
    .rst                  (rst),
    .RegWrite_in          (reg_write),
    .MemtoReg_in          (mem_to_reg),
    .D_MEM_read_data_in   (mem_data),
    .D_MEM_read_addr_in   (alu_data),
    .MEM_WB_RegisterRd_in (rd),
    .rs_addr              (rs_a),
    .rt_addr              (rt_a),
    .rs_data              (rs_data4),
    .rt_data              (rt_data4),
    .wb_data              (wb_data4),
    .wb_count             (wb_count4)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic expect_sig(input sig_e sig, input logic [31:0] exp, input string name);
    exp_t e;
    e.sig  = sig;
    e.exp  = exp;
    e.name = name;
    sb.push_back(e);
  endtask

  // Drive one cycle's inputs shortly after the rising edge.
  task automatic step(input logic r, input logic we, input logic m2r,
                      input logic [31:0] md, input logic [31:0] ad,
                      input logic [4:0] d, input logic [4:0] s, input logic [4:0] t);
    @(posedge clk);
    #1;
    rst        = r;
    reg_write  = we;
    mem_to_reg = m2r;
    mem_data   = md;
    alu_data   = ad;
    rd         = d;
    rs_a       = s;
    rt_a       = t;
  endtask

  // Monitor: compare everything queued for this cycle on the falling edge.
  initial begin
    exp_t  e;
    logic [31:0] act;
    forever begin
      @(negedge clk);
      while (sb.size() > 0) begin
        e = sb.pop_front();
        case (e.sig)
          S_RS:    act = rs_data;
          S_RT:    act = rt_data;
          S_WB:    act = wb_data;
          S_CNT:   act = wb_count;
          S_CNT4:  act = {28'd0, wb_count4};
          S_RS4:   act = rs_data4;
          S_RT4:   act = rt_data4;
          default: act = wb_data4;
        endcase
        check(e.name, act, e.exp);
      end
      if (stim_done) begin
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] v;
    rst = 1'b1; reg_write = 1'b0; mem_to_reg = 1'b0;
    mem_data = '0; alu_data = '0; rd = '0; rs_a = '0; rt_a = '0;
    mcnt = 0;
    for (int i = 0; i < 32; i++) mregs[i] = '0;

    step(1, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1, 2);
    expect_sig(S_CNT, 32'd0, "reset_count");
    expect_sig(S_RS,  32'd0, "reset_r1");

    // Fill every register with random data; bypass shows each value at once.
    for (int i = 1; i < 32; i++) begin
      v = $urandom;
      step(0, 1, 0, 32'h0, v, 5'(i), 5'(i), 5'd0);
      mregs[i] = v;
      mcnt++;
      expect_sig(S_RS, v, "fill_bypass");
      expect_sig(S_RT, 32'd0, "fill_r0");
    end
    step(0, 0, 0, 0, 0, 0, 5'd17, 5'd31);
    expect_sig(S_RS,   mregs[17], "fill_r17");
    expect_sig(S_RT,   mregs[31], "fill_r31");
    expect_sig(S_CNT,  32'(mcnt), "fill_count");
    expect_sig(S_CNT4, 32'(mcnt % 16), "fill_count4");

    // 1: two reset cycles with writes pending; reads forced 0, wb_data live.
    for (int j = 0; j < 2; j++) begin
      step(1, 1, 1, 32'hCAFE_0000 | 32'(j), 32'h0, 5'd4, 5'd4, 5'd4);
      expect_sig(S_RS, 32'd0, "rst_rs_forced");
      expect_sig(S_RT, 32'd0, "rst_rt_forced");
      expect_sig(S_WB, 32'hCAFE_0000 | 32'(j), "rst_wb_mux");
    end
    for (int i = 0; i < 32; i++) begin
      step(0, 0, 0, 0, 0, 0, 5'(i), 5'(31 - i));
      expect_sig(S_RS, 32'd0, "post_rst_rs");
      expect_sig(S_RT, 32'd0, "post_rst_rt");
    end
    expect_sig(S_CNT, 32'd0, "post_rst_count");

    // 2: ALU result to r5, visible through storage next cycle.
    step(0, 1, 0, 32'hBAD0_BAD0, 32'h0000_1234, 5'd5, 5'd5, 5'd6);
    expect_sig(S_RS,  32'h0000_1234, "t2_bypass");
    expect_sig(S_RT,  32'd0, "t2_rt_other");
    expect_sig(S_CNT, 32'd0, "t2_count_before");
    step(0, 0, 0, 0, 0, 0, 5'd5, 5'd0);
    expect_sig(S_RS,  32'h0000_1234, "t2_stored");
    expect_sig(S_CNT, 32'd1, "t2_count");

    // 3: load data to r9, same-cycle bypass on rt.
    step(0, 1, 1, 32'hDEAD_BEEF, 32'h0000_0040, 5'd9, 5'd5, 5'd9);
    expect_sig(S_RT, 32'hDEAD_BEEF, "t3_bypass");
    expect_sig(S_RS, 32'h0000_1234, "t3_rs_r5");
    expect_sig(S_WB, 32'hDEAD_BEEF, "t3_wb");
    step(0, 0, 0, 0, 0, 0, 5'd9, 5'd9);
    expect_sig(S_RS,  32'hDEAD_BEEF, "t3_rs_same");
    expect_sig(S_RT,  32'hDEAD_BEEF, "t3_rt_same");
    expect_sig(S_CNT, 32'd2, "t3_count");

    // 4: write to r0 is not a commit.
    step(0, 1, 1, 32'hFFFF_FFFF, 32'h0, 5'd0, 5'd0, 5'd0);
    expect_sig(S_RS, 32'd0, "t4_r0_rs");
    expect_sig(S_RT, 32'd0, "t4_r0_rt");
    expect_sig(S_WB, 32'hFFFF_FFFF, "t4_wb");
    step(0, 0, 0, 0, 0, 0, 5'd0, 5'd9);
    expect_sig(S_RS,  32'd0, "t4_r0_after");
    expect_sig(S_CNT, 32'd2, "t4_count");

    // 5: preload r7, then RegWrite=0 targeting r7 must neither write nor bypass.
    step(0, 1, 0, 32'h0, 32'h0000_0077, 5'd7, 5'd0, 5'd0);
    step(0, 0, 0, 32'h0, 32'h0000_0055, 5'd7, 5'd7, 5'd7);
    expect_sig(S_RS, 32'h0000_0077, "t5_no_bypass_rs");
    expect_sig(S_RT, 32'h0000_0077, "t5_no_bypass_rt");
    expect_sig(S_WB, 32'h0000_0055, "t5_wb");
    step(0, 0, 0, 0, 0, 0, 5'd7, 5'd0);
    expect_sig(S_RS,  32'h0000_0077, "t5_r7_kept");
    expect_sig(S_CNT, 32'd3, "t5_count");

    // Write to r10 while reading r9/r10: only the matching port bypasses.
    step(0, 1, 0, 32'h0, 32'h0000_1010, 5'd10, 5'd9, 5'd10);
    expect_sig(S_RS, 32'hDEAD_BEEF, "mix_rs_stored");
    expect_sig(S_RT, 32'h0000_1010, "mix_rt_bypass");

    // 6: reset beats a same-edge write to r3.
    step(1, 1, 0, 32'h0, 32'h0000_00A5, 5'd3, 5'd3, 5'd9);
    expect_sig(S_RS, 32'd0, "t6_rs_forced");
    expect_sig(S_WB, 32'h0000_00A5, "t6_wb");
    step(0, 0, 0, 0, 0, 0, 5'd3, 5'd9);
    expect_sig(S_RS,   32'd0, "t6_r3_zero");
    expect_sig(S_RT,   32'd0, "t6_r9_zero");
    expect_sig(S_CNT,  32'd0, "t6_count");
    expect_sig(S_CNT4, 32'd0, "t6_count4");

    // Counter wrap on the 4-bit instance: 15 commits, then the 16th wraps.
    for (int i = 0; i < 15; i++) begin
      step(0, 1, 0, 32'h0, 32'h100 + 32'(i), 5'(i + 1), 5'd0, 5'd0);
    end
    step(0, 0, 0, 0, 0, 0, 5'd15, 5'd1);
    expect_sig(S_CNT4, 32'd15, "wrap_count4_max");
    expect_sig(S_CNT,  32'd15, "wrap_count_15");
    step(0, 1, 0, 32'h0, 32'h0000_010F, 5'd16, 5'd0, 5'd0);
    step(0, 0, 0, 32'h0, 32'h0000_0033, 5'd0, 5'd16, 5'd1);
    expect_sig(S_CNT4, 32'd0, "wrap_count4_zero");
    expect_sig(S_CNT,  32'd16, "wrap_count_16");
    expect_sig(S_RS4,  32'h0000_010F, "wrap_rs4");
    expect_sig(S_RT4,  32'h0000_0100, "wrap_rt4");
    expect_sig(S_WB4,  32'h0000_0033, "wrap_wb4");

    stim_done = 1'b1;
  end

endmodule : tb_wb_regfile
